// File: rtl/th99_bus_pkg.sv
// Shared types and register map for the TH99CHLS MCU bus responder.
// Build option: MCU_BUS_READBACK_EN enables the READ state and the DBUS driver.
package th99_bus_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2,
        READ = 2'd3
    } bus_state_t;

    localparam int REG_B0      = 0;
    localparam int REG_B1      = 1;
    localparam int REG_B2      = 2;
    localparam int REG_B3      = 3;
    localparam int REG_B4      = 4;
    localparam int REG_B5      = 5;
    localparam int REG_B6      = 6;
    localparam int REG_OPERAND = 7;
    localparam int REG_HOUR    = 8;
    localparam int REG_MINUTE  = 9;

    localparam logic [7:0] READ_UNMAPPED = 8'hFF;

    typedef struct packed {
        logic ale_rise;
        logic ale_fall;
        logic wbar_rise;
        logic wbar_fall;
        logic rbar_rise;
        logic rbar_fall;
        logic cs_rise;
        logic cs_fall;
    } bus_edges_t;

endpackage

// File: rtl/mcu_bus_edge_det.sv
// Previous-sample flops and edge flags for the MCU bus strobes.
// The prev flops track the pins unconditionally, so a level held across reset or CSbar never looks like an edge.
module mcu_bus_edge_det
    import th99_bus_pkg::*;
(
    input  logic       clock,
    input  logic       ale,
    input  logic       wbar,
    input  logic       rbar,
    input  logic       csbar,
    output bus_edges_t edges
);

    logic prev_ale, prev_wbar, prev_rbar, prev_csbar;

    always_ff @(posedge clock) begin
        prev_ale   <= ale;
        prev_wbar  <= wbar;
        prev_rbar  <= rbar;
        prev_csbar <= csbar;
    end

    always_comb begin
        edges           = '0;
        edges.ale_rise  = !prev_ale   &&  ale;
        edges.ale_fall  =  prev_ale   && !ale;
        edges.wbar_rise = !prev_wbar  &&  wbar;
        edges.wbar_fall =  prev_wbar  && !wbar;
        edges.rbar_rise = !prev_rbar  &&  rbar;
        edges.rbar_fall =  prev_rbar  && !rbar;
        edges.cs_rise   = !prev_csbar &&  csbar;
        edges.cs_fall   =  prev_csbar && !csbar;
    end

endmodule

// File: rtl/mcu_bus_regfile.sv
// Multiplexed-bus responder holding the TH99CHLS config registers (B0..B6, operand, hour, minute).
// Build option: MCU_BUS_READBACK_EN adds the READ state and drives DBUS with register data.
module mcu_bus_regfile
    import th99_bus_pkg::*;
#(
    parameter int          NUM_REGS  = 10,
    parameter logic [15:0] BASE_ADDR = 16'h0
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [7:0]            ABUS,
    inout  wire  [7:0]            DBUS,
    input  logic                  CSbar,
    input  logic                  ALE,
    input  logic                  Rbar,
    input  logic                  Wbar,
    output logic [NUM_REGS*8-1:0] regs,
    output logic                  wr_strobe,
    output logic [3:0]            wr_index,
    output logic                  bad_addr
);

    bus_state_t                 state;
    bus_edges_t                 edges;
    logic [NUM_REGS-1:0][7:0]   regfile;
    logic [15:0]                addr_q;
    logic [15:0]                idx;
    logic [7:0]                 data_q;
    logic [3:0]                 widx;
    logic                       mapped;

    mcu_bus_edge_det u_edge_det (
        .clock (clock),
        .ale   (ALE),
        .wbar  (Wbar),
        .rbar  (Rbar),
        .csbar (CSbar),
        .edges (edges)
    );

    // Unsigned offset: addresses below BASE_ADDR wrap high and fall out of range.
    assign idx    = addr_q - BASE_ADDR;
    assign mapped = idx < 16'(NUM_REGS);
    assign widx   = idx[3:0];
    assign regs   = regfile;

`ifdef MCU_BUS_READBACK_EN
    logic       drive_en;
    logic [7:0] rd_data;
    logic       unused_edges;

    assign DBUS         = drive_en ? rd_data : 8'bz;
    assign unused_edges = ^{edges.ale_rise, edges.wbar_fall, edges.cs_rise, edges.cs_fall};
`else
    logic unused_edges;

    assign DBUS         = 8'bz;
    assign unused_edges = ^{edges.ale_rise, edges.wbar_fall, edges.cs_rise, edges.cs_fall,
                            edges.rbar_rise, edges.rbar_fall};
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            regfile   <= '0;
            addr_q    <= '0;
            data_q    <= '0;
            wr_strobe <= 1'b0;
            wr_index  <= '0;
            bad_addr  <= 1'b0;
`ifdef MCU_BUS_READBACK_EN
            drive_en  <= 1'b0;
            rd_data   <= '0;
`endif
        end else begin
            wr_strobe <= 1'b0;
            if (CSbar) begin
                // Deselect drops any latched-but-uncommitted write.
                state <= IDLE;
`ifdef MCU_BUS_READBACK_EN
                drive_en <= 1'b0;
`endif
            end else begin
                case (state)
                    IDLE: state <= ADDR;
                    ADDR: begin
                        if (ALE)            addr_q <= {ABUS, DBUS};
                        if (edges.ale_fall) state  <= DATA;
                    end
                    DATA: begin
                        if (!Wbar) data_q <= DBUS;
                        if (edges.wbar_rise) begin
                            if (mapped) begin
                                regfile[widx] <= data_q;
                                wr_strobe     <= 1'b1;
                                wr_index      <= widx;
                            end else begin
                                bad_addr <= 1'b1;
                            end
                        end
                        if (ALE) begin
                            state  <= ADDR;
                            addr_q <= {ABUS, DBUS};
                        end
`ifdef MCU_BUS_READBACK_EN
                        // A write commit in the same sample wins over a read request.
                        else if (edges.rbar_fall && !edges.wbar_rise) begin
                            state    <= READ;
                            drive_en <= 1'b1;
                            rd_data  <= mapped ? regfile[widx] : READ_UNMAPPED;
                            if (!mapped) bad_addr <= 1'b1;
                        end
`endif
                    end
                    READ: begin
`ifdef MCU_BUS_READBACK_EN
                        rd_data <= mapped ? regfile[widx] : READ_UNMAPPED;
                        if (edges.rbar_rise) begin
                            state    <= DATA;
                            drive_en <= 1'b0;
                        end
`else
                        state <= IDLE;
`endif
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
